// File: rtl/cpu_pkg.sv
// Shared CPU types: address/instruction widths and the fetch queue entry.
package cpu_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] inst_t;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fetch_entry_t;

  localparam inst_t NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries. Flush wins over push; a pop in the flush
// cycle is accepted but has no further effect since everything is dropped.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [AW:0]  count
);

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;

  assign head = mem[rd_ptr];

  // Storage write; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues sequential ROM reads under a
// credit limit, buffers returned words and hands them to the core.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter addr_t RESET_PC = '0
) (
  input  logic  clk,
  input  logic  reset,
  output logic  rom_req,
  output addr_t rom_addr,
  input  inst_t rom_data,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  output logic  inst_valid,
  output inst_t inst,
  output addr_t inst_pc,
  input  logic  inst_ready,
  output logic  misaligned_err
);

  localparam int AW = $clog2(DEPTH);

  addr_t        fetch_pc, issued_pc;
  logic         inflight, squash;
  logic [AW:0]  count;
  logic [AW+1:0] used;
  logic         push, pop;
  fetch_entry_t din, head;

  // Credit: queued entries plus the one outstanding read must leave room.
  // Gating with reset makes rom_req drop the moment reset asserts.
  assign used     = {1'b0, count} + (AW+2)'(inflight);
  assign rom_req  = reset && !redirect_valid && (used < (AW+2)'(DEPTH));
  assign rom_addr = fetch_pc;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight && !squash;
  assign din.inst   = rom_data;
  assign din.pc     = issued_pc;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  // Fetch PC, in-flight tracking, squash and sticky misalignment flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc       <= RESET_PC;
      issued_pc      <= '0;
      inflight       <= 1'b0;
      squash         <= 1'b0;
      misaligned_err <= 1'b0;
    end else begin
      inflight <= rom_req;
      squash   <= redirect_valid && inflight;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~addr_t'(3);
        if (redirect_pc[1:0] != 2'b00) misaligned_err <= 1'b1;
      end else if (rom_req) begin
        fetch_pc  <= fetch_pc + addr_t'(4);
        issued_pc <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_inst_fetch_queue;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  rom_req;
  addr_t rom_addr;
  inst_t rom_data = '0;
  logic  redirect_valid = 1'b0;
  addr_t redirect_pc = '0;
  logic  inst_valid;
  inst_t inst;
  addr_t inst_pc;
  logic  inst_ready = 1'b0;
  logic  misaligned_err;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_req        (rom_req),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .misaligned_err (misaligned_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int req_cnt;

  // Reference model state
  addr_t        m_pc;
  fetch_entry_t m_q[$];
  bit           m_infl, m_sq, m_err;
  addr_t        m_ipc;

  function automatic inst_t rom_word(addr_t a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_req();
    return reset && !redirect_valid && (m_q.size() + int'(m_infl)) < 4;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_q.delete(); m_infl = 0; m_sq = 0; m_err = 0; m_ipc = '0;
  endtask

  // Apply inputs for this cycle, let them settle, compare all outputs.
  task automatic drive(bit rdy, bit rv, addr_t rpc);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rom_data       = m_infl ? rom_word(m_ipc) : inst_t'($urandom);
    #1;
    chk("rom_req", rom_req, exp_req());
    if (exp_req()) chk("rom_addr", rom_addr, m_pc);
    chk("inst_valid", inst_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("inst", inst, m_q[0].inst);
      chk("inst_pc", inst_pc, m_q[0].pc);
    end
    chk("misaligned_err", misaligned_err, m_err);
  endtask

  // Clock edge, then advance the model by the same edge.
  task automatic advance();
    bit rq, pop;
    fetch_entry_t e;
    rq  = exp_req();
    pop = (m_q.size() != 0) && inst_ready;
    @(posedge clk); #1;
    if (pop) void'(m_q.pop_front());
    if (redirect_valid) begin
      m_q.delete();
      m_sq   = m_infl;
      m_infl = 0;
      m_pc   = redirect_pc & ~64'd3;
      if (redirect_pc[1:0] != 2'b00) m_err = 1;
    end else begin
      if (m_infl && !m_sq) begin
        e.inst = rom_data;
        e.pc   = m_ipc;
        m_q.push_back(e);
      end
      m_sq = 0;
      if (rq) begin
        m_infl = 1; m_ipc = m_pc; m_pc = m_pc + 64'd4;
      end else begin
        m_infl = 0;
      end
    end
  endtask

  // Assert reset between edges; outputs must drop without waiting for a clock.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_rom_req", rom_req, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, '0);
    chk("rst_inst_pc", inst_pc, '0);
    chk("rst_err", misaligned_err, 1'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    bit    rdy, rv;
    addr_t rpc;
    int    sel;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_rom_req", rom_req, 1'b0);
    chk("por_inst_valid", inst_valid, 1'b0);
    chk("por_inst", inst, '0);
    chk("por_inst_pc", inst_pc, '0);
    chk("por_err", misaligned_err, 1'b0);
    reset = 1'b1;

    // Streaming with inst_ready=1: 0,4,8 then first instruction 2 cycles later
    drive(1, 0, '0);
    chk("s_req0", rom_req, 1'b1);
    chk("s_addr0", rom_addr, 64'h0);
    advance();
    drive(1, 0, '0);
    chk("s_addr1", rom_addr, 64'h4);
    chk("s_valid1", inst_valid, 1'b0);
    advance();
    drive(1, 0, '0);
    chk("s_addr2", rom_addr, 64'h8);
    chk("s_valid2", inst_valid, 1'b1);
    chk("s_pc2", inst_pc, 64'h0);
    chk("s_inst2", inst, 64'hDEAD_0000);
    for (int i = 0; i < 6; i++) begin
      advance();
      drive(1, 0, '0);
    end

    // Back-pressure: exactly four requests, head stable at pc 0
    do_reset();
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, '0);
      if (rom_req) req_cnt++;
      if (inst_valid) chk("bp_pc_stable", inst_pc, 64'h0);
      advance();
    end
    drive(0, 0, '0);
    chk("bp_req_count", req_cnt, 4);
    chk("bp_full_noreq", rom_req, 1'b0);
    chk("bp_valid", inst_valid, 1'b1);
    advance();
    drive(1, 0, '0);
    chk("bp_pop_noreq", rom_req, 1'b0);
    advance();
    drive(0, 0, '0);
    chk("bp_resume_req", rom_req, 1'b1);
    chk("bp_resume_addr", rom_addr, 64'h10);
    advance();

    // Redirect with entries queued and a read in flight
    drive(0, 1, 64'h100);
    advance();
    drive(1, 0, '0);
    chk("rd_flushed", inst_valid, 1'b0);
    chk("rd_req", rom_req, 1'b1);
    chk("rd_addr", rom_addr, 64'h100);
    advance();
    drive(1, 0, '0);
    chk("rd_valid_wait", inst_valid, 1'b0);
    advance();
    drive(1, 0, '0);
    chk("rd_valid", inst_valid, 1'b1);
    chk("rd_pc", inst_pc, 64'h100);
    advance();

    // PC wraps modulo 2^64 without an error
    drive(1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    drive(1, 0, '0);
    chk("wrap_addr_top", rom_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_err", misaligned_err, 1'b0);
    advance();
    drive(1, 0, '0);
    chk("wrap_addr_zero", rom_addr, 64'h0);
    advance();

    // Misaligned redirect: sticky error, fetch from the aligned address
    drive(1, 1, 64'h102);
    advance();
    drive(1, 0, '0);
    chk("mis_err", misaligned_err, 1'b1);
    chk("mis_addr", rom_addr, 64'h100);
    advance();
    drive(1, 1, 64'h200);
    advance();
    drive(1, 0, '0);
    chk("mis_sticky", misaligned_err, 1'b1);
    chk("mis_addr2", rom_addr, 64'h200);
    advance();

    // Random traffic against the model, including back-to-back redirects and resets
    for (int i = 0; i < 4000; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      rpc = {32'h0, $urandom};
      else if (sel == 1) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
      else               rpc = {32'h0, $urandom} & ~64'd3;
      drive(rdy, rv, rpc);
      if ($urandom_range(0, 399) == 0) do_reset();
      else advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
